// File: rtl/fpu_div_mantissa_seq_pkg.sv
// Shared types for the divide-path mantissa datapath: FSM states, iteration
// constants and the result bundle handed to the rounding stage.
package FPU_192_Package;

  localparam int DIV_MANT_W = 24;
  localparam int DIV_EXP_W  = 8;
  localparam int DIV_FMT_W  = 32;
  // Mantissa bits plus guard and round.
  localparam int QUO_BITS   = DIV_MANT_W + 2;
  localparam int DIV_CNT_W  = $clog2(QUO_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic [DIV_MANT_W-1:0] mant;
    logic                  guard;
    logic                  round;
    logic                  sticky;
    logic [DIV_EXP_W-1:0]  expo;
    logic                  sign;
    logic                  overflow;
    logic                  underflow;
    logic                  specialValid;
    logic [DIV_FMT_W-1:0]  specialResult;
  } div_result_t;

endpackage

// File: rtl/fpu_div_mantissa_seq_step.sv
// One restoring-division iteration: trial subtract, quotient bit select and
// remainder shift. Purely combinational so it can be chained for higher radix.
module fpu_div_step #(
  parameter int MANT_W   = 24,
  parameter int QUO_BITS = 26
) (
  input  logic [MANT_W:0]     i_rem,
  input  logic [MANT_W-1:0]   i_divisor,
  input  logic [QUO_BITS-1:0] i_quo,
  output logic [MANT_W:0]     o_remNext,
  output logic [QUO_BITS-1:0] o_quoNext
);

  logic [MANT_W+1:0] w_trial;
  logic              w_bit;

  // The extra top bit of the trial difference acts as the borrow / sign.
  always_comb begin
    w_trial   = {1'b0, i_rem} - {2'b00, i_divisor};
    w_bit     = ~w_trial[MANT_W+1];
    o_remNext = w_bit ? (w_trial[MANT_W:0] << 1) : (i_rem << 1);
    o_quoNext = (i_quo << 1) | QUO_BITS'(w_bit);
  end

endmodule

// File: rtl/fpu_div_mantissa_seq.sv
// Sequential radix-2 restoring mantissa divider with valid/ready handshakes.
// Build option FPU_DIV_EARLY_TERM_EN ends iteration as soon as the remainder is zero.
module fpu_div_mantissa_seq
  import FPU_192_Package::*;
#(
  parameter int MANT_W = DIV_MANT_W,
  parameter int EXP_W  = DIV_EXP_W,
  parameter int FMT_W  = DIV_FMT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] pre_dividend,
  input  logic [MANT_W-1:0] pre_divisor,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic              sign_in,
  input  logic              enable,
  input  logic [FMT_W-1:0]  div_special_result,
  input  logic              pre_overflow,
  input  logic              pre_underflow,
  input  logic              fra_ge,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] quo_mant,
  output logic              quo_guard,
  output logic              quo_round,
  output logic              quo_sticky,
  output logic [EXP_W-1:0]  quo_exp,
  output logic              quo_sign,
  output logic              overflow,
  output logic              underflow,
  output logic              special_valid,
  output logic [FMT_W-1:0]  special_result
);

  div_state_t           r_state;
  logic                 r_inReady;
  logic                 r_outValid;
  logic [MANT_W:0]      r_rem;
  logic [MANT_W-1:0]    r_divisor;
  logic [QUO_BITS-1:0]  r_q;
  logic [DIV_CNT_W-1:0] r_cnt;
  logic [EXP_W-1:0]     r_exp;
  logic                 r_sign;
  logic                 r_overflow;
  logic                 r_underflow;
  logic                 r_special;
  logic [FMT_W-1:0]     r_specialResult;

  logic [MANT_W:0]      w_remNext;
  logic [QUO_BITS-1:0]  w_qNext;
  logic                 w_edgeUnder;
  div_result_t          w_res;

  fpu_div_step #(
    .MANT_W   (MANT_W),
    .QUO_BITS (QUO_BITS)
  ) u_step (
    .i_rem     (r_rem),
    .i_divisor (r_divisor),
    .i_quo     (r_q),
    .o_remNext (w_remNext),
    .o_quoNext (w_qNext)
  );

  // Pre-normalising a smaller dividend costs one exponent; at exponent 0 or 1 that underflows.
  assign w_edgeUnder = !fra_ge && (exp_in <= EXP_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_inReady       <= 1'b1;
      r_outValid      <= 1'b0;
      r_rem           <= '0;
      r_divisor       <= '0;
      r_q             <= '0;
      r_cnt           <= '0;
      r_exp           <= '0;
      r_sign          <= 1'b0;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
      r_special       <= 1'b0;
      r_specialResult <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_inReady       <= 1'b0;
            r_q             <= '0;
            r_divisor       <= pre_divisor;
            r_sign          <= sign_in;
            r_overflow      <= pre_overflow;
            r_underflow     <= pre_underflow | w_edgeUnder;
            r_special       <= !enable;
            r_specialResult <= div_special_result;
            if (enable) begin
              r_state <= CALC;
              r_rem   <= fra_ge ? {1'b0, pre_dividend} : {pre_dividend, 1'b0};
              r_exp   <= w_edgeUnder ? '0 : (fra_ge ? exp_in : exp_in - EXP_W'(1));
              r_cnt   <= DIV_CNT_W'(QUO_BITS - 1);
            end else begin
              r_state    <= DONE;
              r_outValid <= 1'b1;
              r_rem      <= '0;
              r_exp      <= '0;
              r_cnt      <= '0;
            end
          end
        end
        CALC: begin
          r_rem <= w_remNext;
          r_q   <= w_qNext;
          r_cnt <= r_cnt - DIV_CNT_W'(1);
          if (r_cnt == '0) begin
            r_state    <= DONE;
            r_outValid <= 1'b1;
          end
`ifdef FPU_DIV_EARLY_TERM_EN
          // A zero remainder means every remaining quotient bit is zero.
          else if (w_remNext == '0) begin
            r_q        <= w_qNext << r_cnt;
            r_state    <= DONE;
            r_outValid <= 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_res               = '0;
    w_res.mant          = r_q[QUO_BITS-1:2];
    w_res.guard         = r_q[1];
    w_res.round         = r_q[0];
    w_res.sticky        = |r_rem;
    w_res.expo          = r_exp;
    w_res.sign          = r_sign;
    w_res.overflow      = r_overflow;
    w_res.underflow     = r_underflow;
    w_res.specialValid  = r_special;
    w_res.specialResult = r_specialResult;
  end

  assign in_ready       = r_inReady;
  assign out_valid      = r_outValid;
  assign quo_mant       = w_res.mant;
  assign quo_guard      = w_res.guard;
  assign quo_round      = w_res.round;
  assign quo_sticky     = w_res.sticky;
  assign quo_exp        = w_res.expo;
  assign quo_sign       = w_res.sign;
  assign overflow       = w_res.overflow;
  assign underflow      = w_res.underflow;
  assign special_valid  = w_res.specialValid;
  assign special_result = w_res.specialResult;

endmodule

// File: tb/tb_fpu_div_mantissa_seq.sv
// Self-checking bench for fpu_div_mantissa_seq: directed and random divisions
// compared against an arithmetic reference of the quotient and flags.
module tb_fpu_div_mantissa_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] pre_dividend;
  logic [23:0] pre_divisor;
  logic [7:0]  exp_in;
  logic        sign_in;
  logic        enable;
  logic [31:0] div_special_result;
  logic        pre_overflow;
  logic        pre_underflow;
  logic        fra_ge;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] quo_mant;
  logic        quo_guard;
  logic        quo_round;
  logic        quo_sticky;
  logic [7:0]  quo_exp;
  logic        quo_sign;
  logic        overflow;
  logic        underflow;
  logic        special_valid;
  logic [31:0] special_result;

  int errors = 0;
  int checks = 0;

  // Expected values of the operation in flight.
  logic [23:0] expMant;
  logic [2:0]  expGrs;
  logic [7:0]  expExp;
  logic        expSign;
  logic        expOvf;
  logic        expUnf;
  logic        expSpecial;
  logic [31:0] expSpecialResult;
  int          latency;

  always #5 clk = ~clk;

  fpu_div_mantissa_seq dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .pre_dividend       (pre_dividend),
    .pre_divisor        (pre_divisor),
    .exp_in             (exp_in),
    .sign_in            (sign_in),
    .enable             (enable),
    .div_special_result (div_special_result),
    .pre_overflow       (pre_overflow),
    .pre_underflow      (pre_underflow),
    .fra_ge             (fra_ge),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .quo_mant           (quo_mant),
    .quo_guard          (quo_guard),
    .quo_round          (quo_round),
    .quo_sticky         (quo_sticky),
    .quo_exp            (quo_exp),
    .quo_sign           (quo_sign),
    .overflow           (overflow),
    .underflow          (underflow),
    .special_valid      (special_valid),
    .special_result     (special_result)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  // Reference: quotient = floor(R0 * 2^25 / divisor), R0 being the dividend pre-scaled so R0 >= divisor.
  task automatic computeModel(input logic [23:0] a, input logic [23:0] b, input logic [7:0] e,
                              input logic sgn, input logic en, input logic [31:0] spec,
                              input logic po, input logic pu);
    logic [63:0] num;
    logic [63:0] quo;
    logic        edgeUnder;
    logic        ge;
    ge        = (a >= b);
    edgeUnder = !ge && (e <= 8'd1);
    expSign   = sgn;
    expOvf    = po;
    expUnf    = pu || edgeUnder;
    expSpecial       = !en;
    expSpecialResult = spec;
    if (!en) begin
      expMant = '0;
      expGrs  = '0;
      expExp  = '0;
    end else begin
      num     = (ge ? 64'(a) : 64'(a) * 64'd2) * 64'd33554432;
      quo     = num / 64'(b);
      expMant = 24'(quo >> 2);
      expGrs  = {quo[1], quo[0], (num % 64'(b)) != 64'd0};
      if (edgeUnder)
        expExp = 8'h00;
      else
        expExp = ge ? e : e - 8'd1;
    end
  endtask

  // Presents one bundle for a single accepting edge and records the expected result.
  task automatic applyStimulus(input logic [23:0] a, input logic [23:0] b, input logic [7:0] e,
                               input logic sgn, input logic en, input logic [31:0] spec,
                               input logic po, input logic pu);
    @(negedge clk);
    pre_dividend       = a;
    pre_divisor        = b;
    exp_in             = e;
    sign_in            = sgn;
    enable             = en;
    div_special_result = spec;
    pre_overflow       = po;
    pre_underflow      = pu;
    fra_ge             = (a >= b);
    in_valid           = 1'b1;
    computeModel(a, b, e, sgn, en, spec, po, pu);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge until out_valid, bounded.
  task automatic waitResult();
    latency = 1;
    while (out_valid !== 1'b1 && latency < 100) begin
      @(posedge clk);
      @(negedge clk);
      latency++;
    end
    checkOutput("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic checkResult(input string tag, input int wantLatency);
    checkOutput({tag, "_mant"}, 64'(quo_mant), 64'(expMant));
    checkOutput({tag, "_grs"}, 64'({quo_guard, quo_round, quo_sticky}), 64'(expGrs));
    checkOutput({tag, "_exp"}, 64'(quo_exp), 64'(expExp));
    checkOutput({tag, "_sign"}, 64'(quo_sign), 64'(expSign));
    checkOutput({tag, "_flags"}, 64'({overflow, underflow}), 64'({expOvf, expUnf}));
    checkOutput({tag, "_special"}, 64'({special_valid, special_result}), 64'({expSpecial, expSpecialResult}));
`ifdef FPU_DIV_EARLY_TERM_EN
    checkOutput({tag, "_latency_bound"}, 64'(latency <= wantLatency), 64'd1);
`else
    checkOutput({tag, "_latency"}, 64'(latency), 64'(wantLatency));
`endif
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_idle"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    logic [31:0] r;
    logic [23:0] ra;
    logic [23:0] rb;
    logic        ren;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    pre_dividend = '0; pre_divisor = 24'h800000; exp_in = '0; sign_in = 1'b0;
    enable = 1'b0; div_special_result = '0; pre_overflow = 1'b0; pre_underflow = 1'b0; fra_ge = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    checkOutput("reset_handshake", 64'({in_ready, out_valid}), 64'b10);
    checkOutput("reset_data", 64'({quo_mant, quo_guard, quo_round, quo_sticky, quo_exp, special_valid}), 64'd0);
    checkOutput("reset_special", 64'(special_result), 64'd0);

    // 1.5 / 1.0
    applyStimulus(24'hC00000, 24'h800000, 8'h7F, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    waitResult();
    checkResult("d15_10", 27);
    checkOutput("d15_10_const", 64'({quo_mant, quo_guard, quo_round, quo_sticky}), 64'({24'hC00000, 3'b000}));
    releaseResult("d15_10");

    // 1.0 / 1.5 held under backpressure for 10 cycles.
    applyStimulus(24'h800000, 24'hC00000, 8'h7F, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    waitResult();
    checkResult("d10_15", 27);
    checkOutput("d10_15_const", 64'({quo_mant, quo_guard, quo_round, quo_sticky, quo_exp}), 64'({24'hAAAAAA, 3'b101, 8'h7E}));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_stable", 64'({out_valid, in_ready, quo_mant, quo_guard, quo_round, quo_sticky, quo_exp}),
                  64'({1'b1, 1'b0, expMant, expGrs, expExp}));
    end
    releaseResult("hold");

    // Special result, latency 1.
    applyStimulus(24'h900000, 24'h800000, 8'h10, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0);
    waitResult();
    checkResult("special", 1);
    releaseResult("special");

    // Underflow edges and overflow pass-through.
    applyStimulus(24'h800000, 24'hC00000, 8'h01, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    waitResult();
    checkResult("unf_exp1", 27);
    releaseResult("unf_exp1");
    applyStimulus(24'hA00000, 24'hF00000, 8'h00, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    waitResult();
    checkResult("unf_exp0", 27);
    releaseResult("unf_exp0");
    applyStimulus(24'hF00000, 24'hA00000, 8'hFE, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    waitResult();
    checkResult("ovf_pass", 27);

    // A bundle offered during the output handshake must not be taken that cycle.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("no_accept_on_handshake", 64'({in_ready, out_valid}), 64'b10);

    // Reset during iteration 10 aborts silently.
    applyStimulus(24'h800000, 24'hC00000, 8'h7F, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_abort_busy", 64'({in_ready, out_valid}), 64'b00);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_idle", 64'({in_ready, out_valid}), 64'b10);
    latency = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid === 1'b1) latency++;
    end
    checkOutput("abort_no_output", 64'(latency), 64'd0);
    applyStimulus(24'hC00000, 24'h800000, 8'h7F, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    waitResult();
    checkResult("after_abort", 27);
    releaseResult("after_abort");

    // Random operands.
    for (int n = 0; n < 16; n++) begin
      r   = $urandom();
      ra  = {1'b1, r[22:0]};
      r   = $urandom();
      rb  = {1'b1, r[22:0]};
      ren = ($urandom_range(0, 5) != 0);
      r   = $urandom();
      applyStimulus(ra, rb, r[7:0], r[8], ren, $urandom(), (r[11:10] == 2'b00), (r[13:12] == 2'b00));
      waitResult();
      checkResult("random", ren ? 27 : 1);
      releaseResult("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
